// File: rtl/key_mode_ctrl.sv
// rtl/key_mode_ctrl.sv - push-button debouncer with short/long press classification feeding the blink block.
// Define KEY_REPEAT_EN to add auto-repeat key pulses while a long press is held.
module key_mode_ctrl #(
    parameter int   DEBOUNCE_NUM = 250000,
    parameter int   LONG_NUM     = 25000000,
    parameter int   REPEAT_NUM   = 5000000,
    parameter logic KEY_ACTIVE   = 1'b0
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       key_in,
    output logic       key_pulse,
    output logic       long_pulse,
    output logic [1:0] mode,
    output logic       blink_en
);

    localparam int DB_W = (DEBOUNCE_NUM > 1) ? $clog2(DEBOUNCE_NUM) : 1;
    localparam int HD_W = (LONG_NUM > 1) ? $clog2(LONG_NUM) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_NUM - 1);
    localparam logic [HD_W-1:0] HD_LAST = HD_W'(LONG_NUM - 1);

    if (LONG_NUM <= DEBOUNCE_NUM || DEBOUNCE_NUM < 1 || REPEAT_NUM < 1) begin : g_bad_params
        $error("key_mode_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic            pressed_s;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [HD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic            long_flag_q, long_flag_d;
    logic            key_pulse_q, key_pulse_d;
    logic            long_pulse_q, long_pulse_d;
    logic [1:0]      mode_q, mode_d;
    logic            blink_en_q, blink_en_d;

`ifdef KEY_REPEAT_EN
    localparam int RP_W = (REPEAT_NUM > 1) ? $clog2(REPEAT_NUM) : 1;
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_NUM - 1);
    logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    // Synchroniser resets to the released level so reset never looks like a press.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync1_q <= ~KEY_ACTIVE;
            sync2_q <= ~KEY_ACTIVE;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    assign pressed_s = (sync2_q == KEY_ACTIVE);

    always_comb begin
        state_d      = state_q;
        db_cnt_d     = db_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        long_flag_d  = long_flag_q;
        key_pulse_d  = 1'b0;
        long_pulse_d = 1'b0;
        mode_d       = mode_q;
        blink_en_d   = blink_en_q;
`ifdef KEY_REPEAT_EN
        rep_cnt_d    = rep_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pressed_s) begin
                    state_d  = PRESS_DB;
                    db_cnt_d = '0;
                end
            end
            PRESS_DB: begin
                if (!pressed_s) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = HELD;
                    hold_cnt_d  = '0;
                    long_flag_d = 1'b0;
`ifdef KEY_REPEAT_EN
                    rep_cnt_d   = '0;
`endif
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            HELD: begin
                if (hold_cnt_q != HD_LAST) begin
                    hold_cnt_d = hold_cnt_q + HD_W'(1);
                end
                if (hold_cnt_q == HD_LAST && !long_flag_q) begin
                    long_pulse_d = 1'b1;
                    long_flag_d  = 1'b1;
                    blink_en_d   = ~blink_en_q;
                end
`ifdef KEY_REPEAT_EN
                // Repeat phase starts counting in the cycle the long pulse is visible.
                if (long_flag_q) begin
                    if (rep_cnt_q == RP_LAST) begin
                        rep_cnt_d   = '0;
                        key_pulse_d = 1'b1;
                        mode_d      = mode_q + 2'd1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + RP_W'(1);
                    end
                end
`endif
                if (!pressed_s) begin
                    state_d  = RELEASE_DB;
                    db_cnt_d = '0;
                end
            end
            RELEASE_DB: begin
                // A bounce back to pressed resumes the same press; hold count is kept.
                if (pressed_s) begin
                    state_d = HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    if (!long_flag_q) begin
                        key_pulse_d = 1'b1;
                        mode_d      = mode_q + 2'd1;
                    end
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            db_cnt_q     <= '0;
            hold_cnt_q   <= '0;
            long_flag_q  <= 1'b0;
            key_pulse_q  <= 1'b0;
            long_pulse_q <= 1'b0;
            mode_q       <= 2'd0;
            blink_en_q   <= 1'b1;
`ifdef KEY_REPEAT_EN
            rep_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            db_cnt_q     <= db_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            long_flag_q  <= long_flag_d;
            key_pulse_q  <= key_pulse_d;
            long_pulse_q <= long_pulse_d;
            mode_q       <= mode_d;
            blink_en_q   <= blink_en_d;
`ifdef KEY_REPEAT_EN
            rep_cnt_q    <= rep_cnt_d;
`endif
        end
    end

    assign key_pulse  = key_pulse_q;
    assign long_pulse = long_pulse_q;
    assign mode       = mode_q;
    assign blink_en   = blink_en_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// tb/tb_key_mode_ctrl.sv - self-checking bench for key_mode_ctrl with a run-length press model.
module tb_key_mode_ctrl;

    localparam int   D  = 4;
    localparam int   LN = 20;
    localparam int   RN = 5;
    localparam logic KA = 1'b0;
`ifdef KEY_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif
    localparam int EXP_REP = REP ? 3 : 0;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       key_in = 1'b1;
    logic       key_pulse;
    logic       long_pulse;
    logic [1:0] mode;
    logic       blink_en;

    always #5 clk_in = ~clk_in;

    key_mode_ctrl #(
        .DEBOUNCE_NUM(D),
        .LONG_NUM    (LN),
        .REPEAT_NUM  (RN),
        .KEY_ACTIVE  (KA)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .key_in    (key_in),
        .key_pulse (key_pulse),
        .long_pulse(long_pulse),
        .mode      (mode),
        .blink_en  (blink_en)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: debounced level plus run length of opposing samples.
    logic m_hist[$];
    bit   m_down, m_long, m_blink, m_key, m_lpul;
    int   m_run, m_hold, m_rep, m_mode, m_nkey, m_nlong;

    int n_key, n_long, n_both, diverge, tix, long_idx;
    int key_idx_q[$];

    task automatic model_reset();
        m_hist.delete();
        m_hist.push_back(1'b1);
        m_hist.push_back(1'b1);
        m_down = 0; m_long = 0; m_blink = 1; m_key = 0; m_lpul = 0;
        m_run = 0; m_hold = 0; m_rep = 0; m_mode = 0; m_nkey = 0; m_nlong = 0;
    endtask

    task automatic model_step(input logic k);
        logic v;
        bit   p;
        v = m_hist.pop_front();
        m_hist.push_back(k);
        p = (v == KA);
        m_key  = 0;
        m_lpul = 0;
        if (!m_down) begin
            m_run = p ? m_run + 1 : 0;
            if (m_run == D + 1) begin
                m_down = 1; m_run = 0; m_hold = 0; m_long = 0; m_rep = 0;
            end
        end else begin
            if (m_run == 0) begin
                if (m_long && REP) begin
                    m_rep++;
                    if (m_rep == RN) begin
                        m_rep = 0; m_key = 1; m_mode = (m_mode + 1) % 4; m_nkey++;
                    end
                end
                if (m_hold < LN) m_hold++;
                if (m_hold == LN && !m_long) begin
                    m_long = 1; m_lpul = 1; m_blink = !m_blink; m_nlong++;
                end
            end
            m_run = p ? 0 : m_run + 1;
            if (m_run == D + 1) begin
                m_down = 0; m_run = 0;
                if (!m_long) begin
                    m_key = 1; m_mode = (m_mode + 1) % 4; m_nkey++;
                end
            end
        end
    endtask

    task automatic clear_obs();
        n_key = 0; n_long = 0; n_both = 0; diverge = 0; tix = 0; long_idx = -1;
        key_idx_q.delete();
    endtask

    task automatic tick(input logic k);
        key_in = k;
        @(posedge clk_in);
        model_step(k);
        #1;
        if (key_pulse === 1'b1) begin n_key++; key_idx_q.push_back(tix); end
        if (long_pulse === 1'b1) begin n_long++; long_idx = tix; end
        if (key_pulse === 1'b1 && long_pulse === 1'b1) n_both++;
        if (key_pulse !== m_key || long_pulse !== m_lpul ||
            mode !== 2'(m_mode) || blink_en !== m_blink) diverge++;
        tix++;
    endtask

    task automatic ticks(input logic k, input int n);
        for (int i = 0; i < n; i++) tick(k);
    endtask

    task automatic do_reset(input logic k_during);
        key_in = k_during;
        rst_in = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in);
        #2;
        rst_in = 1'b0;
        model_reset();
        clear_obs();
    endtask

    task automatic test_reset();
        #50;
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL rst_mode got=%0d want=0", mode); end
        total++; if (blink_en !== 1'b1) begin bad++; $display("FAIL rst_blink got=%b want=1", blink_en); end
        total++; if (key_pulse !== 1'b0) begin bad++; $display("FAIL rst_key got=%b want=0", key_pulse); end
        total++; if (long_pulse !== 1'b0) begin bad++; $display("FAIL rst_long got=%b want=0", long_pulse); end
        #50;
        rst_in = 1'b0;
        model_reset();
        clear_obs();
        ticks(1'b1, 6);
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL post_rst_mode got=%0d want=0", mode); end
        total++; if (blink_en !== 1'b1) begin bad++; $display("FAIL post_rst_blink got=%b want=1", blink_en); end
        total++; if (n_key + n_long !== 0) begin bad++; $display("FAIL post_rst_pulses got=%0d want=0", n_key + n_long); end
    endtask

    task automatic test_short_press();
        do_reset(1'b1);
        ticks(1'b0, 10);
        ticks(1'b1, 15);
        total++; if (n_key !== 1) begin bad++; $display("FAIL short_count got=%0d want=1", n_key); end
        total++; if (n_key == 1 && key_idx_q[0] !== 16) begin bad++; $display("FAIL short_time got=%0d want=16", key_idx_q[0]); end
        total++; if (mode !== 2'd1) begin bad++; $display("FAIL short_mode got=%0d want=1", mode); end
        total++; if (n_long !== 0) begin bad++; $display("FAIL short_long got=%0d want=0", n_long); end
        total++; if (diverge !== 0) begin bad++; $display("FAIL short_model got=%0d want=0", diverge); end
    endtask

    task automatic test_bounce();
        do_reset(1'b1);
        ticks(1'b0, 3);
        ticks(1'b1, 12);
        total++; if (n_key !== 0) begin bad++; $display("FAIL glitch_count got=%0d want=0", n_key); end
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL glitch_mode got=%0d want=0", mode); end
        clear_obs();
        ticks(1'b0, 8); ticks(1'b1, 2); ticks(1'b0, 6);
        ticks(1'b1, 2); ticks(1'b0, 2); ticks(1'b1, 14);
        total++; if (n_key !== 1) begin bad++; $display("FAIL bounce_count got=%0d want=1", n_key); end
        total++; if (mode !== 2'd1) begin bad++; $display("FAIL bounce_mode got=%0d want=1", mode); end
        total++; if (diverge !== 0) begin bad++; $display("FAIL bounce_model got=%0d want=0", diverge); end
    endtask

    task automatic test_mode_wrap();
        int exp_seq[4] = '{1, 2, 3, 0};
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            ticks(1'b0, 10);
            ticks(1'b1, 10);
            total++;
            if (mode !== 2'(exp_seq[i])) begin
                bad++; $display("FAIL wrap_mode_%0d got=%0d want=%0d", i, mode, exp_seq[i]);
            end
        end
        total++; if (n_key !== 4) begin bad++; $display("FAIL wrap_count got=%0d want=4", n_key); end
    endtask

    task automatic test_long_press();
        do_reset(1'b1);
        ticks(1'b0, 40);
        ticks(1'b1, 20);
        total++; if (n_long !== 1) begin bad++; $display("FAIL long_count got=%0d want=1", n_long); end
        total++; if (long_idx !== 26) begin bad++; $display("FAIL long_time got=%0d want=26", long_idx); end
        total++; if (blink_en !== 1'b0) begin bad++; $display("FAIL long_blink got=%b want=0", blink_en); end
        total++; if (n_key !== EXP_REP) begin bad++; $display("FAIL long_keys got=%0d want=%0d", n_key, EXP_REP); end
        total++; if (mode !== 2'(EXP_REP % 4)) begin bad++; $display("FAIL long_mode got=%0d want=%0d", mode, EXP_REP % 4); end
        total++; if (n_both !== 0) begin bad++; $display("FAIL long_overlap got=%0d want=0", n_both); end
`ifdef KEY_REPEAT_EN
        for (int i = 0; i < 3; i++) begin
            total++;
            if (key_idx_q.size() > i && key_idx_q[i] !== 31 + 5 * i) begin
                bad++; $display("FAIL repeat_time_%0d got=%0d want=%0d", i, key_idx_q[i], 31 + 5 * i);
            end
        end
`endif
        clear_obs();
        ticks(1'b0, 40);
        ticks(1'b1, 20);
        total++; if (blink_en !== 1'b1) begin bad++; $display("FAIL long2_blink got=%b want=1", blink_en); end
        total++; if (n_long !== 1) begin bad++; $display("FAIL long2_count got=%0d want=1", n_long); end
        total++; if (diverge !== 0) begin bad++; $display("FAIL long2_model got=%0d want=0", diverge); end
    endtask

    task automatic test_reset_mid_press();
        do_reset(1'b1);
        ticks(1'b0, 10);
        ticks(1'b1, 10);
        ticks(1'b0, 5);
        #2;
        rst_in = 1'b1;
        #1;
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL midrst_mode got=%0d want=0", mode); end
        total++; if (blink_en !== 1'b1) begin bad++; $display("FAIL midrst_blink got=%b want=1", blink_en); end
        total++; if (key_pulse !== 1'b0 || long_pulse !== 1'b0) begin
            bad++; $display("FAIL midrst_pulse got=%b%b want=00", key_pulse, long_pulse);
        end
        do_reset(1'b1);
        ticks(1'b1, 20);
        total++; if (n_key + n_long !== 0) begin bad++; $display("FAIL midrst_after got=%0d want=0", n_key + n_long); end
        do_reset(1'b0);
        ticks(1'b0, 12);
        ticks(1'b1, 12);
        total++; if (n_key !== 1) begin bad++; $display("FAIL held_thru_rst got=%0d want=1", n_key); end
        total++; if (diverge !== 0) begin bad++; $display("FAIL held_thru_rst_model got=%0d want=0", diverge); end
    endtask

    task automatic test_random();
        int lo, hi;
        do_reset(1'b1);
        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 2))
                0:       lo = $urandom_range(1, 3);
                1:       lo = $urandom_range(8, 16);
                default: lo = $urandom_range(28, 45);
            endcase
            hi = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 2) : $urandom_range(6, 12);
            ticks(1'b0, lo);
            ticks(1'b1, hi);
        end
        ticks(1'b1, 12);
        total++; if (diverge !== 0) begin bad++; $display("FAIL rand_model got=%0d want=0", diverge); end
        total++; if (n_key !== m_nkey) begin bad++; $display("FAIL rand_keys got=%0d want=%0d", n_key, m_nkey); end
        total++; if (n_long !== m_nlong) begin bad++; $display("FAIL rand_longs got=%0d want=%0d", n_long, m_nlong); end
        total++; if (n_both !== 0) begin bad++; $display("FAIL rand_overlap got=%0d want=0", n_both); end
    endtask

    initial begin
        model_reset();
        clear_obs();
        test_reset();
        test_short_press();
        test_bounce();
        test_mode_wrap();
        test_long_press();
        test_reset_mid_press();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
